csr_arbiter: RTL

Two-requester arbiter and sequencer in front of the CSR bank. It shares the single CSR access port between the core's CSR-instruction path (port C) and the hardware event path (port H: interrupt/trap entry writing mepc/mcause/mstatus). It issues at most one CSR operation per cycle and returns the bank's read-back (old) value to the requester that was granted. It sits between the decode stage / interrupt controller and the csr instances.

---
 rtl/decoder_pkg.sv | 30 +++
 rtl/csr_arbiter.sv | 78 +++++++
 2 files changed

// File: rtl/decoder_pkg.sv
// decoder_pkg: shared decode/CSR types, including the CSR arbiter state and owner encodings
package decoder_pkg;

    typedef logic [31:0] word;
    typedef logic [4:0]  r;

    typedef enum logic [2:0] {
        CSR_NOP = 3'd0,
        CSR_RW  = 3'd1,
        CSR_RS  = 3'd2,
        CSR_RC  = 3'd3,
        CSR_RWI = 3'd5,
        CSR_RSI = 3'd6,
        CSR_RCI = 3'd7
    } csr_t;

    typedef logic [11:0] csr_addr_t;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_C,
        OWN_H
    } owner_t;

endpackage

// File: rtl/csr_arbiter.sv
// csr_arbiter: shares the single CSR bank port between the core (C) and hardware event (H) paths
module csr_arbiter
    import decoder_pkg::*;
#(
    parameter int MaxHwStreak = 4,
    parameter int AddrWidth   = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 c_req,
    input  logic [AddrWidth-1:0] c_addr,
    input  csr_t                 c_op,
    input  word                  c_in,
    input  r                     c_rs1,
    output logic                 c_ack,
    output logic                 c_rvalid,
    output word                  c_rdata,
    input  logic                 h_req,
    input  logic [AddrWidth-1:0] h_addr,
    input  csr_t                 h_op,
    input  word                  h_in,
    input  r                     h_rs1,
    output logic                 h_ack,
    output logic                 h_rvalid,
    output word                  h_rdata,
    input  logic                 h_lock,
    output logic                 csr_en,
    output logic [AddrWidth-1:0] csr_addr,
    output csr_t                 csr_op,
    output word                  csr_in,
    output r                     csr_rs1,
    input  word                  csr_old
);

    localparam logic [3:0] StreakMax = 4'(MaxHwStreak);

    arb_state_t state;
    logic [3:0] streak;
    owner_t     owner;
    logic       grant_h;
    logic       grant_c;

    // H wins unless C has waited out the streak; a lock hands the bank to H alone
    always_comb begin
        grant_h = !reset && h_req && (state == LOCKED || streak < StreakMax || !c_req);
        grant_c = !reset && c_req && !grant_h && state == IDLE;
    end

    // bank request mux and per-port responses from the registered owner
    always_comb begin
        c_ack    = grant_c;
        h_ack    = grant_h;
        csr_en   = grant_c || grant_h;
        csr_addr = grant_h ? h_addr : grant_c ? c_addr : '0;
        csr_op   = grant_h ? h_op : grant_c ? c_op : CSR_NOP;
        csr_in   = grant_h ? h_in : grant_c ? c_in : '0;
        csr_rs1  = grant_h ? h_rs1 : grant_c ? c_rs1 : '0;
        c_rvalid = owner == OWN_C;
        h_rvalid = owner == OWN_H;
        c_rdata  = c_rvalid ? csr_old : '0;
        h_rdata  = h_rvalid ? csr_old : '0;
    end

    // lock state, saturating H streak seen by a waiting C, and response owner
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            streak <= '0;
            owner  <= OWN_NONE;
        end else begin
            if (grant_h) state <= h_lock ? LOCKED : IDLE;
            if (!c_req || grant_c) streak <= '0;
            else if (grant_h && streak != StreakMax) streak <= streak + 4'd1;
            owner <= grant_h ? OWN_H : grant_c ? OWN_C : OWN_NONE;
        end
    end

endmodule
